dwpw_layer_sequencer: RTL and testbench
=======================================

Name: dwpw_layer_sequencer

Overview:
- Run controller for the depthwise + pointwise accelerator top.
- Accepts one serial weight stream. Writes CIN*9 depthwise kernel bytes, then COUT*CIN pointwise weight bytes, into the accelerator's weight write ports.
- Then opens a gate on the pixel input stream for exactly one frame, counts output beats, and signals completion.
- Sits between the DMA/host side and the accelerator top; replaces direct host driving of the weight ports.

Parameters:
- DATA_W, 8, weight/pixel element width.
- CIN, 32, input channels; depthwise weight count = CIN*9.
- COUT, 64, output channels; pointwise weight count = COUT*CIN.
- NUM_IN_PIX, 50176, input pixel beats per frame (224*224).
- NUM_OUT_PIX, 50176, output pixel beats per frame that end a run.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle run request.
- skip_load  in  1  sampled with start; 1 = reuse resident weights and go straight to RUN.
- s_wt_tdata  in  DATA_W  serial weight bytes (DW block first, then PW).
- s_wt_tvalid  in  1  weight beat valid.
- s_wt_tready  out  1  weight beat accepted.
- dw_kernel_wr_en  out  1  depthwise kernel write strobe.
- dw_kernel_wr_addr  out  $clog2(CIN*9)  depthwise write address.
- dw_kernel_wr_data  out  DATA_W  depthwise write data.
- pw_wr_en  out  1  pointwise weight write strobe.
- pw_wr_addr  out  $clog2(COUT*CIN)  pointwise write address.
- pw_wr_data  out  DATA_W  pointwise write data.
- up_tvalid  in  1  upstream pixel valid.
- up_tready  out  1  upstream pixel ready (gated).
- acc_tvalid  out  1  pixel valid into accelerator (gated).
- acc_tready  in  1  accelerator pixel ready.
- mon_tvalid  in  1  accelerator output valid (monitor only).
- mon_tready  in  1  downstream output ready (monitor only).
- busy  out  1  high in any state except IDLE/DONE.
- done  out  1  one-cycle pulse on RUN->DONE.
- o_intr  out  1  level interrupt, set with done, cleared by start or reset.

Behaviour:
- Clock/reset: single clock clk. reset is synchronous, active-high. Reset mid-operation returns to IDLE in one cycle and aborts any load/run; resident weights in the accelerator are not touched.
- Reset values: all outputs 0, all counters 0, state IDLE.
- States: IDLE, LOAD_DW, LOAD_PW, RUN, DONE.
- IDLE/DONE + start:
  - skip_load=0 -> LOAD_DW.
  - skip_load=1 -> RUN.
  - Either way: o_intr cleared; wt_idx, in_cnt, out_cnt cleared.
  - start is ignored in LOAD_DW/LOAD_PW/RUN.
- Weight handshake:
  - s_wt_tready = 1 only in LOAD_DW/LOAD_PW; 0 otherwise, so beats outside a load stall.
  - Beat accepted when s_wt_tvalid & s_wt_tready.
- Write ports are registered, 1-cycle latency:
  - Cycle after an accepted beat in LOAD_DW: dw_kernel_wr_en=1, dw_kernel_wr_addr=wt_idx at acceptance, dw_kernel_wr_data=tdata at acceptance.
  - LOAD_PW drives the pw_* ports the same way.
  - wr_en is 0 on every other cycle.
  - dw and pw strobes are never high together.
- Load transitions and bubbles:
  - Beat CIN*9-1 accepted in LOAD_DW -> LOAD_PW, wt_idx=0.
  - Beat COUT*CIN-1 accepted in LOAD_PW -> RUN.
  - tvalid gaps insert write bubbles with no address advance.
- Gate (combinational):
  - open = (state==RUN) & (in_cnt < NUM_IN_PIX).
  - acc_tvalid = up_tvalid & open; up_tready = acc_tready & open.
  - in_cnt increments on up_tvalid & up_tready and saturates at NUM_IN_PIX; extra upstream pixels are held, not dropped.
- Output count and done:
  - out_cnt increments on mon_tvalid & mon_tready in RUN.
  - On the handshake that makes out_cnt == NUM_OUT_PIX: -> DONE; done pulses next cycle; o_intr set and held.
  - If the last input and last output handshake in the same cycle, both counts are taken.
- Counter widths: $clog2(max+1); no wrap is possible by construction.

Optional Feature:
- Macro SEQ_PERF_CNT_EN.
- With the macro defined:
  - Extra output run_cycles (32 bits) counts clk cycles spent in RUN, saturating at 2^32-1.
  - Cleared on start and on reset; holds its value in DONE.
- Without the macro: the port and counter are absent, and behaviour is otherwise identical.

Test Plan:
- Full load: CIN=2, COUT=2; start, skip_load=0; stream 18+4 bytes 0x01..0x16 -> dw writes addr 0..17 carry data 0x01..0x12, pw writes addr 0..3 carry 0x13..0x16; each write lands 1 cycle after its handshake; then state RUN.
- Backpressure/gaps: s_wt_tvalid toggling 1/0 -> writes only on the cycle after each accepted beat; no duplicate or skipped addresses; s_wt_tready=0 in IDLE and RUN.
- Run gating: NUM_IN_PIX=NUM_OUT_PIX=4; upstream offers 6 pixels; acc_tready random -> exactly 4 pass; up_tready stays 0 after the 4th. 4 monitor handshakes -> done pulse, o_intr=1, busy=0.
- skip_load=1: start -> RUN next cycle; no write strobes; s_wt_tready stays 0.
- Reset mid-load: reset after 5 DW beats -> all outputs 0 next cycle, state IDLE. A new start reloads from addr 0.
- start during RUN: pulse start -> ignored, counts unaffected. start in DONE -> o_intr clears the next cycle.

Source files
------------

// File: rtl/dwpw_layer_sequencer_if.sv
// Handshake, weight-write and pixel-gate bundle between host/DMA, sequencer and accelerator.
// The run_cycles member exists only when SEQ_PERF_CNT_EN is defined.
interface dwpw_layer_sequencer_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CIN    = 32,
  parameter int unsigned COUT   = 64
);
  localparam int unsigned DW_AW = (CIN * 9 > 1) ? $clog2(CIN * 9) : 1;
  localparam int unsigned PW_AW = (COUT * CIN > 1) ? $clog2(COUT * CIN) : 1;

  logic              start;
  logic              skip_load;
  logic [DATA_W-1:0] s_wt_tdata;
  logic              s_wt_tvalid;
  logic              s_wt_tready;
  logic              dw_kernel_wr_en;
  logic [DW_AW-1:0]  dw_kernel_wr_addr;
  logic [DATA_W-1:0] dw_kernel_wr_data;
  logic              pw_wr_en;
  logic [PW_AW-1:0]  pw_wr_addr;
  logic [DATA_W-1:0] pw_wr_data;
  logic              up_tvalid;
  logic              up_tready;
  logic              acc_tvalid;
  logic              acc_tready;
  logic              mon_tvalid;
  logic              mon_tready;
  logic              busy;
  logic              done;
  logic              o_intr;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0]       run_cycles;
`endif

  modport master (
`ifdef SEQ_PERF_CNT_EN
    input  run_cycles,
`endif
    output start, skip_load, s_wt_tdata, s_wt_tvalid, up_tvalid, acc_tready,
           mon_tvalid, mon_tready,
    input  s_wt_tready, dw_kernel_wr_en, dw_kernel_wr_addr, dw_kernel_wr_data,
           pw_wr_en, pw_wr_addr, pw_wr_data, up_tready, acc_tvalid, busy, done, o_intr
  );

  modport slave (
`ifdef SEQ_PERF_CNT_EN
    output run_cycles,
`endif
    input  start, skip_load, s_wt_tdata, s_wt_tvalid, up_tvalid, acc_tready,
           mon_tvalid, mon_tready,
    output s_wt_tready, dw_kernel_wr_en, dw_kernel_wr_addr, dw_kernel_wr_data,
           pw_wr_en, pw_wr_addr, pw_wr_data, up_tready, acc_tvalid, busy, done, o_intr
  );
endinterface

// File: rtl/dwpw_layer_sequencer.sv
// Run controller: streams DW then PW weights into the accelerator, gates one frame of pixels, counts outputs.
// Optional SEQ_PERF_CNT_EN adds a saturating run_cycles counter of cycles spent in RUN.
module dwpw_layer_sequencer #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned CIN         = 32,
  parameter int unsigned COUT        = 64,
  parameter int unsigned NUM_IN_PIX  = 50176,
  parameter int unsigned NUM_OUT_PIX = 50176
) (
  input logic                   clk,
  input logic                   reset,
  dwpw_layer_sequencer_if.slave bus
);
  localparam int unsigned DW_N   = CIN * 9;
  localparam int unsigned PW_N   = COUT * CIN;
  localparam int unsigned DW_AW  = (DW_N > 1) ? $clog2(DW_N) : 1;
  localparam int unsigned PW_AW  = (PW_N > 1) ? $clog2(PW_N) : 1;
  localparam int unsigned WT_MAX = (DW_N > PW_N) ? DW_N : PW_N;
  localparam int unsigned WT_W   = $clog2(WT_MAX + 1);
  localparam int unsigned IN_W   = $clog2(NUM_IN_PIX + 1);
  localparam int unsigned OUT_W  = $clog2(NUM_OUT_PIX + 1);

  typedef enum logic [2:0] {IDLE, LOAD_DW, LOAD_PW, RUN, DONE} state_t;

  state_t          state;
  logic [WT_W-1:0] wt_idx;
  logic [IN_W-1:0] in_cnt;
  logic [OUT_W-1:0] out_cnt;
  logic            gate_open;
  logic            wt_fire;
  logic            in_fire;
  logic            out_fire;
  logic            start_ok;

  // Pixel gate closes once the frame's input count is reached; surplus pixels stay upstream.
  assign gate_open       = (state == RUN) && (in_cnt < IN_W'(NUM_IN_PIX));
  assign bus.acc_tvalid  = bus.up_tvalid & gate_open;
  assign bus.up_tready   = bus.acc_tready & gate_open;
  assign bus.s_wt_tready = (state == LOAD_DW) || (state == LOAD_PW);

  assign wt_fire  = bus.s_wt_tvalid & bus.s_wt_tready;
  assign in_fire  = bus.up_tvalid & bus.up_tready;
  assign out_fire = bus.mon_tvalid & bus.mon_tready & (state == RUN);
  assign start_ok = bus.start & ((state == IDLE) || (state == DONE));

  always_ff @(posedge clk) begin
    if (reset) begin
      state                 <= IDLE;
      wt_idx                <= '0;
      in_cnt                <= '0;
      out_cnt               <= '0;
      bus.dw_kernel_wr_en   <= 1'b0;
      bus.dw_kernel_wr_addr <= '0;
      bus.dw_kernel_wr_data <= '0;
      bus.pw_wr_en          <= 1'b0;
      bus.pw_wr_addr        <= '0;
      bus.pw_wr_data        <= '0;
      bus.busy              <= 1'b0;
      bus.done              <= 1'b0;
      bus.o_intr            <= 1'b0;
    end else begin
      bus.dw_kernel_wr_en <= 1'b0;
      bus.pw_wr_en        <= 1'b0;
      bus.done            <= 1'b0;
      if (in_fire) in_cnt <= in_cnt + IN_W'(1);
      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            state      <= bus.skip_load ? RUN : LOAD_DW;
            bus.busy   <= 1'b1;
            bus.o_intr <= 1'b0;
            wt_idx     <= '0;
            in_cnt     <= '0;
            out_cnt    <= '0;
          end
        end
        LOAD_DW: begin
          if (wt_fire) begin
            bus.dw_kernel_wr_en   <= 1'b1;
            bus.dw_kernel_wr_addr <= DW_AW'(wt_idx);
            bus.dw_kernel_wr_data <= bus.s_wt_tdata;
            if (wt_idx == WT_W'(DW_N - 1)) begin
              state  <= LOAD_PW;
              wt_idx <= '0;
            end else begin
              wt_idx <= wt_idx + WT_W'(1);
            end
          end
        end
        LOAD_PW: begin
          if (wt_fire) begin
            bus.pw_wr_en   <= 1'b1;
            bus.pw_wr_addr <= PW_AW'(wt_idx);
            bus.pw_wr_data <= bus.s_wt_tdata;
            if (wt_idx == WT_W'(PW_N - 1)) begin
              state  <= RUN;
              wt_idx <= '0;
            end else begin
              wt_idx <= wt_idx + WT_W'(1);
            end
          end
        end
        RUN: begin
          if (out_fire) begin
            out_cnt <= out_cnt + OUT_W'(1);
            if (out_cnt == OUT_W'(NUM_OUT_PIX - 1)) begin
              state      <= DONE;
              bus.busy   <= 1'b0;
              bus.done   <= 1'b1;
              bus.o_intr <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SEQ_PERF_CNT_EN
  // Cycles spent in RUN; holds through DONE until the next start.
  always_ff @(posedge clk) begin
    if (reset || start_ok) begin
      bus.run_cycles <= '0;
    end else if ((state == RUN) && (bus.run_cycles != '1)) begin
      bus.run_cycles <= bus.run_cycles + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_dwpw_layer_sequencer.sv
// Self-checking bench for dwpw_layer_sequencer: vector table, directed multi-cycle sequences, random traffic vs a reference model.
module tb_dwpw_layer_sequencer;
  localparam int unsigned CIN  = 2;
  localparam int unsigned COUT = 2;
  localparam int unsigned NIN  = 4;
  localparam int unsigned NOUT = 4;
  localparam int          DWN  = 18;
  localparam int          PWN  = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dwpw_layer_sequencer_if #(.DATA_W(8), .CIN(CIN), .COUT(COUT)) bus ();

  dwpw_layer_sequencer #(
    .DATA_W(8), .CIN(CIN), .COUT(COUT), .NUM_IN_PIX(NIN), .NUM_OUT_PIX(NOUT)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 loading, 2 running, 3 done; weights counted across both blocks.
  int       ph = 0, n_wt = 0, in_n = 0, out_n = 0;
  bit       intr_m = 0, done_m = 0, gate_m, mon_en = 0;
  bit       e_dw_en = 0, e_pw_en = 0;
  logic [4:0] e_dw_addr = '0;
  logic [1:0] e_pw_addr = '0;
  logic [7:0] e_dw_data = '0, e_pw_data = '0;
  int       dw_seen = 0, pw_seen = 0;

  task automatic model_step();
    e_dw_en = 0; e_pw_en = 0; done_m = 0;
    if (reset) begin
      ph = 0; n_wt = 0; in_n = 0; out_n = 0; intr_m = 0;
      e_dw_addr = '0; e_dw_data = '0; e_pw_addr = '0; e_pw_data = '0;
    end else begin
      case (ph)
        0, 3: if (bus.start) begin
          intr_m = 0; n_wt = 0; in_n = 0; out_n = 0;
          ph = bus.skip_load ? 2 : 1;
        end
        1: if (bus.s_wt_tvalid) begin
          if (n_wt < DWN) begin
            e_dw_en = 1; e_dw_addr = 5'(n_wt); e_dw_data = bus.s_wt_tdata;
          end else begin
            e_pw_en = 1; e_pw_addr = 2'(n_wt - DWN); e_pw_data = bus.s_wt_tdata;
          end
          n_wt++;
          if (n_wt == DWN + PWN) ph = 2;
        end
        2: begin
          if (bus.up_tvalid && bus.acc_tready && in_n < NIN) in_n++;
          if (bus.mon_tvalid && bus.mon_tready) begin
            out_n++;
            if (out_n == NOUT) begin ph = 3; done_m = 1; intr_m = 1; end
          end
        end
        default: ;
      endcase
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      gate_m = (ph == 2) && (in_n < NIN);
      chk("busy", 32'(bus.busy), 32'(ph == 1 || ph == 2));
      chk("done", 32'(bus.done), 32'(done_m));
      chk("o_intr", 32'(bus.o_intr), 32'(intr_m));
      chk("s_wt_tready", 32'(bus.s_wt_tready), 32'(ph == 1));
      chk("acc_tvalid", 32'(bus.acc_tvalid), 32'(bus.up_tvalid & gate_m));
      chk("up_tready", 32'(bus.up_tready), 32'(bus.acc_tready & gate_m));
      chk("dw_wr_en", 32'(bus.dw_kernel_wr_en), 32'(e_dw_en));
      chk("dw_wr_addr", 32'(bus.dw_kernel_wr_addr), 32'(e_dw_addr));
      chk("dw_wr_data", 32'(bus.dw_kernel_wr_data), 32'(e_dw_data));
      chk("pw_wr_en", 32'(bus.pw_wr_en), 32'(e_pw_en));
      chk("pw_wr_addr", 32'(bus.pw_wr_addr), 32'(e_pw_addr));
      chk("pw_wr_data", 32'(bus.pw_wr_data), 32'(e_pw_data));
      if (bus.dw_kernel_wr_en === 1'b1) dw_seen++;
      if (bus.pw_wr_en === 1'b1) pw_seen++;
      model_step();
    end
  end

  typedef struct packed {
    bit rst, start, skip, up_v, acc_r, mon_v, mon_r;
    bit busy, done, intr, acc_v, up_r, wt_r;
  } vec_t;
  vec_t tbl[16];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_inputs();
    bus.start = 0; bus.skip_load = 0; bus.s_wt_tvalid = 0; bus.s_wt_tdata = '0;
    bus.up_tvalid = 0; bus.acc_tready = 0; bus.mon_tvalid = 0; bus.mon_tready = 0;
  endtask

  task automatic start_run(input bit skip);
    bus.start = 1; bus.skip_load = skip; tick();
    bus.start = 0; bus.skip_load = 0;
  endtask

  // gap_mode: 0 none, 1 alternating, 2 random
  task automatic send_beats(input int n, input int first_byte, input int gap_mode);
    int sent = 0, k = 0, budget;
    bit v;
    budget = n * 4 + 20;
    while (sent < n && budget > 0) begin
      v = (gap_mode == 0) ? 1'b1 : (gap_mode == 1) ? (k % 2 == 0) : ($urandom_range(0, 1) == 1);
      bus.s_wt_tvalid = v;
      bus.s_wt_tdata  = 8'(first_byte + sent);
      if (v && bus.s_wt_tready === 1'b1) sent++;
      k++; budget--;
      tick();
    end
    bus.s_wt_tvalid = 0;
    chk("beats_accepted", 32'(sent), 32'(n));
  endtask

  initial begin
    int passed, hs;
    tbl[0]  = 13'b0110000_000000;
    tbl[1]  = 13'b0001100_100110;
    tbl[2]  = 13'b0001000_100100;
    tbl[3]  = 13'b0000100_100010;
    tbl[4]  = 13'b0101100_100110;
    tbl[5]  = 13'b0001111_100110;
    tbl[6]  = 13'b0001110_100110;
    tbl[7]  = 13'b0001111_100000;
    tbl[8]  = 13'b0001111_100000;
    tbl[9]  = 13'b0000011_100000;
    tbl[10] = 13'b0000000_011000;
    tbl[11] = 13'b0000000_001000;
    tbl[12] = 13'b0110000_001000;
    tbl[13] = 13'b0000100_100010;
    tbl[14] = 13'b1000100_100010;
    tbl[15] = 13'b0000000_000000;

    clear_inputs();
    reset = 1;
    @(posedge clk); #1;
    mon_en = 1;
    tick();
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_dw_addr", 32'(bus.dw_kernel_wr_addr), 32'd0);
    reset = 0;

    // Vector table: skip_load run, gating, start ignored in RUN, done/intr, start in DONE, reset in RUN.
    for (int i = 0; i < 16; i++) begin
      reset = tbl[i].rst; bus.start = tbl[i].start; bus.skip_load = tbl[i].skip;
      bus.up_tvalid = tbl[i].up_v; bus.acc_tready = tbl[i].acc_r;
      bus.mon_tvalid = tbl[i].mon_v; bus.mon_tready = tbl[i].mon_r;
      @(negedge clk);
      chk($sformatf("tbl%0d_busy", i), 32'(bus.busy), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d_done", i), 32'(bus.done), 32'(tbl[i].done));
      chk($sformatf("tbl%0d_intr", i), 32'(bus.o_intr), 32'(tbl[i].intr));
      chk($sformatf("tbl%0d_acc_tvalid", i), 32'(bus.acc_tvalid), 32'(tbl[i].acc_v));
      chk($sformatf("tbl%0d_up_tready", i), 32'(bus.up_tready), 32'(tbl[i].up_r));
      chk($sformatf("tbl%0d_wt_tready", i), 32'(bus.s_wt_tready), 32'(tbl[i].wt_r));
      @(posedge clk); #1;
    end
    reset = 0;
    clear_inputs();

    // Weight beats offered in IDLE must stall.
    bus.s_wt_tvalid = 1; bus.s_wt_tdata = 8'hAA;
    repeat (3) begin
      chk("idle_wt_tready", 32'(bus.s_wt_tready), 32'd0);
      tick();
    end
    bus.s_wt_tvalid = 0;

    // Full load, no gaps, bytes 0x01..0x16.
    start_run(1'b0);
    dw_seen = 0; pw_seen = 0;
    send_beats(DWN + PWN, 1, 0);
    tick();
    chk("full_dw_writes", 32'(dw_seen), 32'(DWN));
    chk("full_pw_writes", 32'(pw_seen), 32'(PWN));
    chk("full_run_busy", 32'(bus.busy), 32'd1);
    chk("run_wt_tready", 32'(bus.s_wt_tready), 32'd0);

    // Gating: upstream keeps offering (6 pixels available), only 4 may pass.
    passed = 0;
    for (int c = 0; c < 30; c++) begin
      bus.up_tvalid = 1;
      bus.acc_tready = (c >= 20) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      if (bus.up_tready === 1'b1) passed++;
      tick();
    end
    bus.up_tvalid = 0; bus.acc_tready = 1;
    #1;
    chk("gate_passed", 32'(passed), 32'(NIN));
    chk("gate_closed", 32'(bus.up_tready), 32'd0);
    tick();
    bus.acc_tready = 0;

    hs = 0;
    for (int b = 0; b < 40 && hs < NOUT; b++) begin
      bus.mon_tvalid = 1; bus.mon_tready = 1'($urandom_range(0, 1));
      #1;
      if (bus.mon_tready) hs++;
      tick();
    end
    bus.mon_tvalid = 0; bus.mon_tready = 0;
    chk("mon_handshakes", 32'(hs), 32'(NOUT));
    chk("done_pulse", 32'(bus.done), 32'd1);
    chk("done_intr", 32'(bus.o_intr), 32'd1);
    chk("done_busy", 32'(bus.busy), 32'd0);
    tick();
    chk("done_pulse_end", 32'(bus.done), 32'd0);

    // Reload from DONE with alternating valid gaps.
    start_run(1'b0);
    chk("restart_intr_clear", 32'(bus.o_intr), 32'd0);
    dw_seen = 0; pw_seen = 0;
    send_beats(DWN + PWN, 8'h40, 1);
    tick();
    chk("gap_dw_writes", 32'(dw_seen), 32'(DWN));
    chk("gap_pw_writes", 32'(pw_seen), 32'(PWN));

    // Reset mid-load after 5 DW beats, then reload from address 0.
    reset = 1; tick(); reset = 0;
    start_run(1'b0);
    send_beats(5, 8'h80, 0);
    reset = 1; tick(); reset = 0;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_wt_tready", 32'(bus.s_wt_tready), 32'd0);
    chk("midrst_dw_en", 32'(bus.dw_kernel_wr_en), 32'd0);
    chk("midrst_dw_addr", 32'(bus.dw_kernel_wr_addr), 32'd0);
    chk("midrst_dw_data", 32'(bus.dw_kernel_wr_data), 32'd0);
    dw_seen = 0; pw_seen = 0;
    start_run(1'b0);
    send_beats(DWN + PWN, 8'hC0, 2);
    tick();
    chk("reload_dw_writes", 32'(dw_seen), 32'(DWN));
    chk("reload_pw_writes", 32'(pw_seen), 32'(PWN));

    // Random traffic; the negedge model checks every output each cycle.
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      bus.start = ($urandom_range(0, 11) == 0);
      bus.skip_load = 1'($urandom_range(0, 1));
      bus.s_wt_tvalid = ($urandom_range(0, 3) != 0);
      bus.s_wt_tdata = 8'($urandom);
      bus.up_tvalid = 1'($urandom_range(0, 1));
      bus.acc_tready = ($urandom_range(0, 3) != 0);
      bus.mon_tvalid = 1'($urandom_range(0, 1));
      bus.mon_tready = ($urandom_range(0, 3) != 0);
      tick();
    end
    reset = 0;
    clear_inputs();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
